// File: rtl/psu_pkg.sv
// Shared definitions for the PSU ADC emulation blocks: word-format defaults
// and the responder frame state encoding.
package psu_pkg;

    localparam int ADC_WIDTH_DEF    = 12;
    localparam int LEAD_BITS_DEF    = 4;
    localparam int WORDS_PER_CS_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        DATA  = 2'd2,
        TRAIL = 2'd3
    } adc_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous pin, followed by a third flop
// that produces single-clk rise/fall pulses on the synchronized level.
module sync_edge_det #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic sync_prev;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
        if (rst) begin
            meta      <= RESET_VAL;
            sync      <= RESET_VAL;
            sync_prev <= RESET_VAL;
        end else begin
            meta      <= din;
            sync      <= meta;
            sync_prev <= sync;
        end
    end

    assign rise = sync & ~sync_prev;
    assign fall = ~sync & sync_prev;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI ADC emulator: serializes 12-bit samples as LEAD_BITS zeros plus
// MSB-first data, repeated WORDS_PER_CS times per cs-low window.
module adc_spi_responder
    import psu_pkg::*;
#(
    parameter int ADC_WIDTH    = ADC_WIDTH_DEF,
    parameter int LEAD_BITS    = LEAD_BITS_DEF,
    parameter int WORDS_PER_CS = WORDS_PER_CS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADC_WIDTH-1:0] sample_data,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    input  logic                 cs,
    input  logic                 sck,
    output logic                 dout,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 underrun,
    input  logic                 clr_underrun
);

    localparam int MAX_CNT = (LEAD_BITS > ADC_WIDTH) ? LEAD_BITS : ADC_WIDTH;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = $clog2(WORDS_PER_CS) + 1;

    localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(LEAD_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(ADC_WIDTH - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WORDS_PER_CS - 1);

    // Synchronized pin events.
    logic cs_rise;
    logic cs_fall;
    logic sck_fall;
    logic sck_rise_unused;

    // cs idles high, so its synchronizer resets high to avoid a false cs_fall.
    sync_edge_det #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    sync_edge_det #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sck),
        .rise (sck_rise_unused),
        .fall (sck_fall)
    );

    adc_state_e           state,       state_next;
    logic [ADC_WIDTH-1:0] shreg,       shreg_next;
    logic [ADC_WIDTH-1:0] word_sample, word_sample_next;
    logic [ADC_WIDTH-1:0] hold,        hold_next;
    logic                 hold_full,   hold_full_next;
    logic [ADC_WIDTH-1:0] last_sample, last_sample_next;
    logic [CNT_W-1:0]     bit_cnt,     bit_cnt_next;
    logic [IDX_W-1:0]     word_idx,    word_idx_next;
    logic                 dout_q,      dout_next;
    logic                 done_q,      done_next;
    logic                 underrun_q,  underrun_next;
    logic                 underrun_set;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Datapath and output registers; everything returns to reset on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            word_sample <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            last_sample <= '0;
            bit_cnt     <= '0;
            word_idx    <= '0;
            dout_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            shreg       <= shreg_next;
            word_sample <= word_sample_next;
            hold        <= hold_next;
            hold_full   <= hold_full_next;
            last_sample <= last_sample_next;
            bit_cnt     <= bit_cnt_next;
            word_idx    <= word_idx_next;
            dout_q      <= dout_next;
            done_q      <= done_next;
            underrun_q  <= underrun_next;
        end
    end

    // Next-state, framing and holding-register control.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_next       = state;
        shreg_next       = shreg;
        word_sample_next = word_sample;
        hold_next        = hold;
        hold_full_next   = hold_full;
        last_sample_next = last_sample;
        bit_cnt_next     = bit_cnt;
        word_idx_next    = word_idx;
        dout_next        = dout_q;
        done_next        = 1'b0;
        underrun_set     = 1'b0;

        // Ordinary handshake into the single-entry holding register.
        if (sample_valid && !hold_full) begin
            hold_next      = sample_data;
            hold_full_next = 1'b1;
        end

        unique case (state)
            IDLE: begin
                dout_next = 1'b0;
                if (cs_fall) begin
                    state_next    = LEAD;
                    bit_cnt_next  = '0;
                    word_idx_next = '0;
                    if (hold_full) begin
                        word_sample_next = hold;
                        hold_full_next   = 1'b0;
                    end else if (sample_valid) begin
                        // Bypass: the offered sample goes straight to the shifter.
                        word_sample_next = sample_data;
                        hold_full_next   = 1'b0;
                    end else begin
                        word_sample_next = last_sample;
                        underrun_set     = 1'b1;
                    end
                    shreg_next = word_sample_next;
                end
            end

            LEAD: begin
                dout_next = 1'b0;
                if (cs_rise) begin
                    state_next = IDLE;
                end else if (sck_fall) begin
                    if (bit_cnt == LEAD_LAST) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                        dout_next    = shreg[ADC_WIDTH-1];
                        shreg_next   = {shreg[ADC_WIDTH-2:0], 1'b0};
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end

            DATA: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    dout_next  = 1'b0;
                end else if (sck_fall) begin
                    if (bit_cnt == DATA_LAST) begin
                        dout_next    = 1'b0;
                        bit_cnt_next = '0;
                        if (word_idx < WORD_LAST) begin
                            state_next    = LEAD;
                            shreg_next    = word_sample;
                            word_idx_next = word_idx + 1'b1;
                        end else begin
                            state_next       = TRAIL;
                            done_next        = 1'b1;
                            last_sample_next = word_sample;
                        end
                    end else begin
                        dout_next    = shreg[ADC_WIDTH-1];
                        shreg_next   = {shreg[ADC_WIDTH-2:0], 1'b0};
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end

            TRAIL: begin
                dout_next = 1'b0;
                if (cs_rise) state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase

        // A new underrun outranks a simultaneous clear.
        if (underrun_set)      underrun_next = 1'b1;
        else if (clr_underrun) underrun_next = 1'b0;
        else                   underrun_next = underrun_q;
    end

    assign sample_ready = !hold_full;
    assign dout         = dout_q;
    assign busy         = (state != IDLE);
    assign frame_done   = done_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: a table of sample windows plus
// hand-written bypass, abort and mid-frame reset sequences.
module tb_adc_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        cs;
    logic        sck;
    logic        dout;
    logic        busy;
    logic        frame_done;
    logic        underrun;
    logic        clr_underrun;

    adc_spi_responder dut (
        .clk          (clk),
        .rst          (rst),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .cs           (cs),
        .sck          (sck),
        .dout         (dout),
        .busy         (busy),
        .frame_done   (frame_done),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    logic [15:0] exp_q[$];
    logic [15:0] rx_word;

    typedef struct {
        logic        push;
        logic [11:0] value;
        logic [11:0] exp_word;
        logic        exp_underrun;
    } vec_t;

    vec_t vecs[6];

    always @(negedge clk) if (frame_done) fd_cnt++;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_sample(input logic [11:0] v);
        int n;
        n = 0;
        sample_data  = v;
        sample_valid = 1'b1;
        while (!sample_ready && n < 100) begin
            tick(1);
            n++;
        end
        if (n == 100) check("push_timeout", 32'd1, 32'd0);
        tick(1);
        sample_valid = 1'b0;
    endtask

    task automatic expect_sample(input logic [11:0] v);
        exp_q.push_back({4'b0, v});
        exp_q.push_back({4'b0, v});
    endtask

    // Drives a cs-low window of n sck periods (6 clk per phase), sampling dout
    // just before each rising sck edge and scoring every completed 16-bit word.
    task automatic run_frame(input int n, input bit release_cs);
        cs      = 1'b0;
        rx_word = '0;
        tick(6);
        for (int i = 0; i < n; i++) begin
            rx_word = {rx_word[14:0], dout};
            sck = 1'b1;
            tick(6);
            sck = 1'b0;
            tick(6);
            if ((i % 16) == 15) begin
                if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
                else                   check("word", {16'd0, rx_word}, {16'd0, exp_q.pop_front()});
            end
        end
        if (release_cs) begin
            cs = 1'b1;
            tick(8);
        end
    endtask

    initial begin
        int          fd0;
        logic [15:0] abort_word;

        vecs[0] = '{1'b1, 12'd100, 12'd100, 1'b0};
        vecs[1] = '{1'b1, 12'd300, 12'd300, 1'b0};
        vecs[2] = '{1'b1, 12'd400, 12'd400, 1'b0};
        vecs[3] = '{1'b1, 12'd300, 12'd300, 1'b0};
        vecs[4] = '{1'b1, 12'd400, 12'd400, 1'b0};
        vecs[5] = '{1'b0, 12'd0,   12'd400, 1'b1};

        rst          = 1'b1;
        cs           = 1'b1;
        sck          = 1'b0;
        sample_data  = '0;
        sample_valid = 1'b0;
        clr_underrun = 1'b0;
        tick(3);
        check("reset_dout",       {31'd0, dout},         32'd0);
        check("reset_busy",       {31'd0, busy},         32'd0);
        check("reset_frame_done", {31'd0, frame_done},   32'd0);
        check("reset_underrun",   {31'd0, underrun},     32'd0);
        check("reset_ready",      {31'd0, sample_ready}, 32'd1);
        rst = 1'b0;
        tick(2);

        // Table: pushed samples, then one no-push window that must underrun.
        for (int i = 0; i < 6; i++) begin
            fd0 = fd_cnt;
            if (vecs[i].push) begin
                check("ready_before_push", {31'd0, sample_ready}, 32'd1);
                push_sample(vecs[i].value);
                check("ready_hold_full", {31'd0, sample_ready}, 32'd0);
            end
            expect_sample(vecs[i].exp_word);
            run_frame(32, 1'b1);
            check("frame_done_once", fd_cnt - fd0, 32'd1);
            check("queue_drained", exp_q.size(), 32'd0);
            check("ready_after_frame", {31'd0, sample_ready}, 32'd1);
            check("underrun_flag", {31'd0, underrun}, {31'd0, vecs[i].exp_underrun});
            if (vecs[i].exp_underrun) begin
                clr_underrun = 1'b1;
                tick(1);
                clr_underrun = 1'b0;
                check("underrun_cleared", {31'd0, underrun}, 32'd0);
            end
        end

        // Bypass: sample_valid coincides with the synchronized cs_fall.
        fd0 = fd_cnt;
        tick(1);
        cs = 1'b0;
        tick(2);
        sample_data  = 12'd200;
        sample_valid = 1'b1;
        check("bypass_ready", {31'd0, sample_ready}, 32'd1);
        tick(1);
        sample_valid = 1'b0;
        check("bypass_hold_empty", {31'd0, sample_ready}, 32'd1);
        check("bypass_busy", {31'd0, busy}, 32'd1);
        expect_sample(12'd200);
        run_frame(32, 1'b1);
        check("bypass_frame_done", fd_cnt - fd0, 32'd1);
        check("bypass_underrun", {31'd0, underrun}, 32'd0);

        // Abort: cs rises after 10 sck periods of a 300 frame.
        push_sample(12'd300);
        fd0 = fd_cnt;
        run_frame(10, 1'b0);
        abort_word = {4'b0, 12'd300};
        check("abort_partial_bits", {22'd0, rx_word[9:0]}, {22'd0, abort_word[15:6]});
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        cs = 1'b1;
        tick(3);
        check("abort_dout", {31'd0, dout}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        tick(6);
        check("abort_no_frame_done", fd_cnt - fd0, 32'd0);
        push_sample(12'd400);
        expect_sample(12'd400);
        run_frame(32, 1'b1);
        check("after_abort_underrun", {31'd0, underrun}, 32'd0);

        // Reset during DATA with a sample waiting in hold.
        push_sample(12'd300);
        run_frame(7, 1'b0);
        check("pre_reset_dout", {31'd0, dout}, 32'd1);
        push_sample(12'd100);
        check("pre_reset_ready", {31'd0, sample_ready}, 32'd0);
        rst = 1'b1;
        cs  = 1'b1;
        sck = 1'b0;
        tick(1);
        check("mid_reset_dout",       {31'd0, dout},         32'd0);
        check("mid_reset_busy",       {31'd0, busy},         32'd0);
        check("mid_reset_frame_done", {31'd0, frame_done},   32'd0);
        check("mid_reset_underrun",   {31'd0, underrun},     32'd0);
        check("mid_reset_ready",      {31'd0, sample_ready}, 32'd1);
        tick(4);
        rst = 1'b0;
        tick(2);
        fd0 = fd_cnt;
        push_sample(12'd100);
        expect_sample(12'd100);
        run_frame(32, 1'b1);
        check("post_reset_frame_done", fd_cnt - fd0, 32'd1);
        check("post_reset_queue", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Synthesizable SPI ADC emulator: the responder end of the ADC read link used by each PSU rail controller (sck/cs driven by the controller, din returned).
- Serializes supplied 12-bit samples in the ADC frame format so rail controllers can be exercised in hardware-in-loop builds without a real converter.
- Sits beside PSU_Top_Level. Its dout connects to a rail's din, and it is clocked from the same system clock.

Parameters:
- ADC_WIDTH, 12, data bits per word.
- LEAD_BITS, 4, zero bits before each word's data.
- WORDS_PER_CS, 2, words sent per cs-low window. The same sample is repeated in every word.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sample_data  in  ADC_WIDTH  next sample value.
- sample_valid  in  1  sample_data is valid.
- sample_ready  out  1  holding register empty. A sample is accepted when valid && ready.
- cs  in  1  chip select from the controller, active low, asynchronous to clk.
- sck  in  1  serial clock from the controller, asynchronous to clk.
- dout  out  1  serial data to the controller's din.
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-clk pulse when all WORDS_PER_CS words have completed.
- underrun  out  1  sticky flag: cs fell while the holding register was empty.
- clr_underrun  in  1  clears underrun.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: dout=0, busy=0, frame_done=0, underrun=0, sample_ready=1, holding register empty, last-sample register 0.
- Input synchronization: cs and sck each pass through a 2-flop synchronizer plus edge detect. Events (cs_fall, cs_rise, sck_fall) are seen 3 clk after the pin edge.
- Timing constraint: sck high and low phases must each be ≥ 4 clk. dout changes 3 clk after the sck falling edge, so it is stable before the controller samples on the rising edge.
- Holding register (1 entry):
  - sample_ready = !hold_full.
  - Accepting a sample sets hold_full.
- Word framing: each word is LEAD_BITS zeros followed by ADC_WIDTH data bits, MSB first. Each word is 16 sck periods at the defaults.
- State machine states: IDLE, LEAD, DATA, TRAIL.
- IDLE:
  - dout=0.
  - On cs_fall: shift register loads hold if hold_full, clearing hold_full; state→LEAD; busy=1; bit counter=0.
  - If hold is empty and sample_valid=1 in the same cycle, the bypass applies: load sample_data directly and assert sample_ready that cycle, counting it as accepted.
  - If hold is empty and sample_valid=0: reload last-sample and set underrun.
- LEAD:
  - dout=0.
  - Each sck_fall increments the counter.
  - On the LEAD_BITS-th sck_fall: state→DATA and dout=MSB.
- DATA:
  - Each sck_fall shifts the next bit onto dout.
  - After the ADC_WIDTH-th bit period, one of two things happens:
    - If the word index is below WORDS_PER_CS-1: the shift register reloads the same sample, the word index increments, and state→LEAD.
    - Otherwise: state→TRAIL, frame_done pulses, and last-sample is updated.
- TRAIL:
  - dout=0 for any further sck edges.
  - On cs_rise: state→IDLE, busy=0.
- cs_rise in LEAD or DATA (abort):
  - Immediate return to IDLE, dout=0, busy=0.
  - No frame_done; last-sample is not updated.
  - The consumed sample is discarded, not restored to hold.
- sck_fall while in IDLE: ignored.
- underrun priority: if clr_underrun and an underrun set occur in the same cycle, the set wins.
- rst asserted mid-frame: every register returns to its reset value on the next clk edge.
- Width rules:
  - Bit counter width is clog2(max(LEAD_BITS, ADC_WIDTH)+1).
  - Word index width is clog2(WORDS_PER_CS)+1.
  - No arithmetic wraps.

Decomposition:
- Shared package psu_pkg holds:
  - the ADC_WIDTH and LEAD_BITS defaults;
  - the state enum {IDLE, LEAD, DATA, TRAIL}.
- One natural sub-module: sync_edge_det, a 2-flop synchronizer plus rise/fall pulse generator. It is instantiated once for cs and once for sck.

Test Plan:
1. Push sample 100, then run a cs-low window of 32 sck periods.
   - Required: dout sequence 0000_000001100100, sent twice.
   - frame_done pulses once; sample_ready returns to 1.
2. Push samples 300, 400, 300, 400 across four consecutive cs windows.
   - Required: each window carries the correct value twice.
   - underrun stays 0.
   - sample_ready deasserts only while hold is full.
3. No sample pushed before a cs fall, with last sample 400.
   - Required: 400 is retransmitted and underrun=1.
   - clr_underrun then returns underrun to 0.
4. sample_valid rises in the same clk as the synchronized cs_fall, with hold empty and sample 200.
   - Required: 200 is transmitted, the bypass accept fires, and underrun=0.
5. cs rises after 10 sck periods of a 300 frame.
   - Required: dout=0 and busy=0 within 1 clk of cs_rise; no frame_done.
   - The next frame uses the next pushed sample.
6. rst asserted during DATA of a frame.
   - Required: all outputs are at their reset values on the next clk.
   - A subsequent frame sending 100 is bit-exact.
